// File: rtl/lamp_fpu_sqrt_arbiter.sv
`default_nettype none
// lamp_fpu_sqrt_arbiter: round-robin sharing of one lampFPU sqrt / inv-sqrt unit,
// one op in flight, timeout-protected, id-tagged backpressured response. Rev 1.0
module lamp_fpu_sqrt_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int OP_DW          = 16,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req_valid_i,
   input  logic [NUM_REQ-1:0]         req_inv_i,
   input  logic [NUM_REQ*OP_DW-1:0]   req_operand_i,
   output logic [NUM_REQ-1:0]         req_ready_o,
   output logic                       fpu_doSqrt_o,
   output logic                       fpu_doInvSqrt_o,
   output logic [OP_DW-1:0]           fpu_operand_o,
   input  logic [OP_DW-1:0]           fpu_result_i,
   input  logic                       fpu_valid_i,
   output logic                       rsp_valid_o,
   input  logic                       rsp_ready_i,
   output logic [$clog2(NUM_REQ)-1:0] rsp_id_o,
   output logic [OP_DW-1:0]           rsp_result_o,
   output logic                       rsp_err_o,
   output logic                       busy_o,
   output logic                       stray_o
);

   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

   typedef logic [ID_W-1:0]  id_t;
   typedef logic [ID_W:0]    idx_t;
   typedef logic [CNT_W-1:0] cnt_t;

   localparam idx_t             NUM_EXT  = idx_t'(NUM_REQ);
   localparam id_t              LAST_ID  = id_t'(NUM_REQ - 1);
   localparam cnt_t             CNT_LAST = cnt_t'(TIMEOUT_CYCLES - 1);
   localparam logic [OP_DW-1:0] QNAN     = OP_DW'(16'h7FC0);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t           state;
   state_t           state_nxt;
   id_t              ptr;
   id_t              id;
   logic             op;
   logic [OP_DW-1:0] operand;
   logic [OP_DW-1:0] result;
   logic             err;
   cnt_t             cnt;
   logic             stray;

   idx_t             idx;
   logic             found;
   id_t              grant;
   id_t              grant_inc;
   logic             accept;

   // Rotating priority search starting at ptr, wrapping modulo NUM_REQ.
   always_comb begin
      found = 1'b0;
      grant = '0;
      idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = {1'b0, ptr} + idx_t'(k);
         if (idx >= NUM_EXT) begin
            idx = idx - NUM_EXT;
         end
         if (!found && req_valid_i[idx[ID_W-1:0]]) begin
            found = 1'b1;
            grant = idx[ID_W-1:0];
         end
      end
   end

   assign grant_inc = (grant == LAST_ID) ? '0 : grant + 1'b1;
   assign accept    = (state == IDLE) && found;

   // Ready is gated by rst so it also reads zero while reset is held.
   always_comb begin
      req_ready_o = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         req_ready_o[i] = accept && !rst && (grant == id_t'(i));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = ISSUE;
         ISSUE:   state_nxt = WAIT;
         WAIT:    if (fpu_valid_i || (cnt == CNT_LAST)) state_nxt = RESP;
         RESP:    if (rsp_ready_i) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr     <= '0;
         id      <= '0;
         op      <= 1'b0;
         operand <= '0;
         result  <= '0;
         err     <= 1'b0;
         cnt     <= '0;
         stray   <= 1'b0;
      end else begin
         if (fpu_valid_i && (state != WAIT)) begin
            stray <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (accept) begin
                  id      <= grant;
                  op      <= req_inv_i[grant];
                  operand <= req_operand_i[grant*OP_DW +: OP_DW];
                  ptr     <= grant_inc;
               end
            end
            ISSUE: begin
               cnt <= '0;
            end
            WAIT: begin
               // A result arriving in the last counted cycle beats the timeout.
               if (fpu_valid_i) begin
                  result <= fpu_result_i;
                  err    <= 1'b0;
               end else if (cnt == CNT_LAST) begin
                  result <= QNAN;
                  err    <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign fpu_doSqrt_o    = (state == ISSUE) && !op;
   assign fpu_doInvSqrt_o = (state == ISSUE) && op;
   assign fpu_operand_o   = (state == IDLE) ? '0 : operand;
   assign rsp_valid_o     = (state == RESP);
   assign rsp_id_o        = (state == RESP) ? id : '0;
   assign rsp_result_o    = (state == RESP) ? result : '0;
   assign rsp_err_o       = (state == RESP) && err;
   assign busy_o          = (state != IDLE);
   assign stray_o         = stray;

endmodule
`default_nettype wire

// File: tb/tb_lamp_fpu_sqrt_arbiter.sv
`default_nettype none
// Directed bench for lamp_fpu_sqrt_arbiter: scoreboarded responses, cycle-exact
// start-pulse / response timing, fairness, backpressure, timeout, stray, reset.
module tb_lamp_fpu_sqrt_arbiter;

   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req_valid_i = '0;
   logic [3:0]  req_inv_i = '0;
   logic [63:0] req_operand_i;
   logic [3:0]  req_ready_o;
   logic        fpu_doSqrt_o;
   logic        fpu_doInvSqrt_o;
   logic [15:0] fpu_operand_o;
   logic [15:0] fpu_result_i = 16'hDEAD;
   logic        fpu_valid_i = 1'b0;
   logic        rsp_valid_o;
   logic        rsp_ready_i = 1'b0;
   logic [1:0]  rsp_id_o;
   logic [15:0] rsp_result_o;
   logic        rsp_err_o;
   logic        busy_o;
   logic        stray_o;

   logic [15:0] operands [4] = '{16'h3F80, 16'h4080, 16'h4100, 16'h4180};

   typedef struct packed {
      logic [1:0]  id;
      logic [15:0] res;
      logic        err;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   lamp_fpu_sqrt_arbiter #(
      .NUM_REQ        (4),
      .OP_DW          (16),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .req_valid_i     (req_valid_i),
      .req_inv_i       (req_inv_i),
      .req_operand_i   (req_operand_i),
      .req_ready_o     (req_ready_o),
      .fpu_doSqrt_o    (fpu_doSqrt_o),
      .fpu_doInvSqrt_o (fpu_doInvSqrt_o),
      .fpu_operand_o   (fpu_operand_o),
      .fpu_result_i    (fpu_result_i),
      .fpu_valid_i     (fpu_valid_i),
      .rsp_valid_o     (rsp_valid_o),
      .rsp_ready_i     (rsp_ready_i),
      .rsp_id_o        (rsp_id_o),
      .rsp_result_o    (rsp_result_o),
      .rsp_err_o       (rsp_err_o),
      .busy_o          (busy_o),
      .stray_o         (stray_o)
   );

   always #5 clk = ~clk;

   assign req_operand_i = {operands[3], operands[2], operands[1], operands[0]};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ready"},   32'(req_ready_o), 0);
      check({tag, "_pulses"},  32'({fpu_doSqrt_o, fpu_doInvSqrt_o}), 0);
      check({tag, "_operand"}, 32'(fpu_operand_o), 0);
      check({tag, "_rsp"},     32'({rsp_valid_o, rsp_id_o, rsp_err_o}), 0);
      check({tag, "_result"},  32'(rsp_result_o), 0);
      check({tag, "_busy"},    32'(busy_o), 0);
      check({tag, "_stray"},   32'(stray_o), 0);
   endtask

   task automatic idle_cycle();
      @(negedge clk);
      rsp_ready_i = 1'b0;
      req_valid_i = '0;
      fpu_valid_i = 1'b0;
   endtask

   // lat = 0 means the unit stays silent; hold = cycles of response backpressure.
   task automatic run_op(input logic [3:0] mask, input int gid, input logic inv,
                         input int lat, input logic [15:0] res, input int hold);
      int          rc;
      exp_t        e;
      exp_t        got;
      logic [15:0] opnd;
      opnd = operands[gid];
      rc   = (lat > 0) ? 2 + lat : 2 + TO;
      @(negedge clk);
      rsp_ready_i = 1'b0;
      req_valid_i = mask;
      req_inv_i   = {4{inv}};
      #1;
      check("idle_busy", 32'(busy_o), 0);
      check("idle_rsp_valid", 32'(rsp_valid_o), 0);
      check("grant", 32'(req_ready_o), 32'(1) << gid);
      e.id  = 2'(gid);
      e.res = (lat > 0) ? res : 16'h7FC0;
      e.err = (lat == 0);
      sb.push_back(e);
      for (int c = 1; c <= rc; c++) begin
         @(negedge clk);
         fpu_valid_i  = (lat > 0) && (c == 1 + lat);
         fpu_result_i = fpu_valid_i ? res : 16'hDEAD;
         #1;
         check("do_sqrt", 32'(fpu_doSqrt_o), 32'(c == 1 && !inv));
         check("do_inv_sqrt", 32'(fpu_doInvSqrt_o), 32'(c == 1 && inv));
         check("operand", 32'(fpu_operand_o), 32'(opnd));
         check("ready_while_busy", 32'(req_ready_o), 0);
         check("busy", 32'(busy_o), 1);
         check("rsp_valid_timing", 32'(rsp_valid_o), 32'(c == rc));
      end
      if (sb.size() == 0) begin
         checks++;
         failures++;
         $error("FAIL scoreboard_underflow observed=0 expected=1");
      end else begin
         got = sb.pop_front();
         for (int h = 0; h <= hold; h++) begin
            if (h > 0) begin
               @(negedge clk);
               #1;
            end
            check("rsp_valid_hold", 32'(rsp_valid_o), 1);
            check("rsp_id", 32'(rsp_id_o), 32'(got.id));
            check("rsp_result", 32'(rsp_result_o), 32'(got.res));
            check("rsp_err", 32'(rsp_err_o), 32'(got.err));
            check("hold_ready", 32'(req_ready_o), 0);
            check("hold_pulses", 32'({fpu_doSqrt_o, fpu_doInvSqrt_o}), 0);
            check("hold_operand", 32'(fpu_operand_o), 32'(opnd));
         end
      end
      rsp_ready_i = 1'b1;
   endtask

   initial begin
      // Reset with all requesters asking: nothing may leak out.
      req_valid_i = 4'b1111;
      repeat (2) @(negedge clk);
      #1;
      check_all_zero("reset");
      req_valid_i = '0;
      rst = 1'b0;

      // Single sqrt request from requester 1, unit answers at L = 6.
      run_op(4'b0010, 1, 1'b0, 6, 16'h4000, 0);
      // ptr = 2: requesters 0 and 3 valid -> 3 wins; 10 cycles of backpressure.
      run_op(4'b1001, 3, 1'b0, 2, 16'h3FB5, 10);
      // Grant the cycle after ready rises; inverse sqrt from requester 0.
      run_op(4'b0011, 0, 1'b1, 3, 16'h3F00, 0);
      // Silent unit -> timeout error response.
      run_op(4'b0100, 2, 1'b0, 0, 16'h0000, 0);
      // Valid in the last WAIT cycle wins over the timeout.
      run_op(4'b0100, 2, 1'b1, TO, 16'h3EB5, 0);

      // Stray valid pulse in IDLE is ignored but sticky.
      idle_cycle();
      #1;
      check("stray_before", 32'(stray_o), 0);
      @(negedge clk);
      fpu_valid_i  = 1'b1;
      fpu_result_i = 16'h1234;
      @(negedge clk);
      fpu_valid_i = 1'b0;
      #1;
      check("stray_set", 32'(stray_o), 1);
      check("stray_no_rsp", 32'({rsp_valid_o, busy_o}), 0);
      repeat (3) idle_cycle();
      #1;
      check("stray_sticky", 32'(stray_o), 1);

      // Reset while waiting for the unit.
      @(negedge clk);
      req_valid_i = 4'b0001;
      req_inv_i   = 4'b0000;
      #1;
      check("rst_op_grant", 32'(req_ready_o), 32'h1);
      @(negedge clk);
      req_valid_i = '0;
      #1;
      check("rst_op_pulse", 32'(fpu_doSqrt_o), 1);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      check_all_zero("async_reset");
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_all_zero("after_reset");

      // Fairness from a freshly reset pointer: 0, 1, 2, 3, then wrap to 0.
      run_op(4'b1111, 0, 1'b0, 1, 16'h3F80, 0);
      run_op(4'b1111, 1, 1'b0, 1, 16'h4000, 0);
      run_op(4'b1111, 2, 1'b1, 1, 16'h3F35, 0);
      run_op(4'b1111, 3, 1'b0, 2, 16'h4040, 0);
      run_op(4'b1111, 0, 1'b0, 1, 16'h3F81, 0);
      idle_cycle();
      #1;
      check("final_idle", 32'({busy_o, rsp_valid_o}), 0);
      check("scoreboard_drained", 32'(sb.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1);
   end

endmodule
`default_nettype wire
